// File: rtl/full_adder.sv
// Single-bit full adder with a combinational result, a valid-qualified
// registered copy of it, and saturating operation/carry statistics counters.
module full_adder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             sum,
  output logic             cout,
  input  logic             in_valid,
  output logic             sum_q,
  output logic             cout_q,
  output logic             out_valid,
  input  logic             clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             res_sum_d,   res_sum_q;
  logic             res_cout_d,  res_cout_q;
  logic             valid_d,     valid_q;
  logic [CNT_W-1:0] op_cnt_d,    op_cnt_q;
  logic [CNT_W-1:0] carry_cnt_d, carry_cnt_q;

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

  always_comb begin
    res_sum_d   = res_sum_q;
    res_cout_d  = res_cout_q;
    valid_d     = in_valid;
    op_cnt_d    = op_cnt_q;
    carry_cnt_d = carry_cnt_q;

    if (in_valid) begin
      res_sum_d  = sum;
      res_cout_d = cout;
    end

    // clr wins over a same-cycle operation; the result path above is unaffected
    if (clr) begin
      op_cnt_d    = '0;
      carry_cnt_d = '0;
    end else if (in_valid) begin
      if (op_cnt_q != CNT_MAX) begin
        op_cnt_d = op_cnt_q + 1'b1;
      end
      if (cout && (carry_cnt_q != CNT_MAX)) begin
        carry_cnt_d = carry_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_q   <= 1'b0;
      res_cout_q  <= 1'b0;
      valid_q     <= 1'b0;
      op_cnt_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      res_sum_q   <= res_sum_d;
      res_cout_q  <= res_cout_d;
      valid_q     <= valid_d;
      op_cnt_q    <= op_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign sum_q       = res_sum_q;
  assign cout_q      = res_cout_q;
  assign out_valid   = valid_q;
  assign op_count    = op_cnt_q;
  assign carry_count = carry_cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: truth-table vectors, directed registered/counter/reset
// sequences, and random traffic against an arithmetic reference model.
module tb_full_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a, b, cin, in_valid, clr;

  logic        sum16, cout16, sum_q16, cout_q16, out_valid16;
  logic [15:0] op16, car16;
  logic        sum4, cout4, sum_q4, cout_q4, out_valid4;
  logic [3:0]  op4, car4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state
  logic   m_sum, m_cout, m_valid;
  longint m_ops, m_car;

  typedef struct {
    logic a, b, cin;
    logic exp_sum, exp_cout;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  full_adder #(.CNT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum16), .cout(cout16), .in_valid(in_valid),
    .sum_q(sum_q16), .cout_q(cout_q16), .out_valid(out_valid16),
    .clr(clr), .op_count(op16), .carry_count(car16)
  );

  full_adder #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum4), .cout(cout4), .in_valid(in_valid),
    .sum_q(sum_q4), .cout_q(cout_q4), .out_valid(out_valid4),
    .clr(clr), .op_count(op4), .carry_count(car4)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    m_sum = 1'b0; m_cout = 1'b0; m_valid = 1'b0; m_ops = 0; m_car = 0;
  endtask

  task automatic check_comb();
    int s;
    s = int'(a) + int'(b) + int'(cin);
    chk("sum16",  longint'(sum16),  longint'(s % 2));
    chk("cout16", longint'(cout16), longint'(s / 2));
    chk("sum4",   longint'(sum4),   longint'(s % 2));
    chk("cout4",  longint'(cout4),  longint'(s / 2));
  endtask

  task automatic check_regs();
    chk("sum_q16",     longint'(sum_q16),     longint'(m_sum));
    chk("cout_q16",    longint'(cout_q16),    longint'(m_cout));
    chk("out_valid16", longint'(out_valid16), longint'(m_valid));
    chk("op_count16",  longint'(op16),        sat(m_ops, 16));
    chk("carry16",     longint'(car16),       sat(m_car, 16));
    chk("sum_q4",      longint'(sum_q4),      longint'(m_sum));
    chk("cout_q4",     longint'(cout_q4),     longint'(m_cout));
    chk("out_valid4",  longint'(out_valid4),  longint'(m_valid));
    chk("op_count4",   longint'(op4),         sat(m_ops, 4));
    chk("carry4",      longint'(car4),        sat(m_car, 4));
  endtask

  // Advance the model with the inputs currently applied, then clock and compare.
  task automatic step();
    int s;
    s = int'(a) + int'(b) + int'(cin);
    if (in_valid) begin
      m_sum  = logic'(s % 2);
      m_cout = logic'(s / 2);
    end
    m_valid = in_valid;
    if (clr) begin
      m_ops = 0; m_car = 0;
    end else if (in_valid) begin
      m_ops++;
      if (s >= 2) m_car++;
    end
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic set_in(input logic ia, input logic ib, input logic ic,
                        input logic iv, input logic icl);
    a = ia; b = ib; cin = ic; in_valid = iv; clr = icl;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_regs();

    // combinational truth table, exercised while still in reset
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      #1;
      chk("tt_sum",  longint'(sum16),  longint'(vecs[i].exp_sum));
      chk("tt_cout", longint'(cout16), longint'(vecs[i].exp_cout));
      chk("tt_sum4", longint'(sum4),   longint'(vecs[i].exp_sum));
    end

    @(negedge clk);
    rst_n = 1'b1;

    // all eight combinations accepted back to back
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, 1'b0);
      step();
    end
    chk("ops_after_8",   longint'(op16),  8);
    chk("carry_after_8", longint'(car16), 4);

    // registered path: capture then hold
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("rp_sum_q",  longint'(sum_q16),     1);
    chk("rp_cout_q", longint'(cout_q16),    1);
    chk("rp_valid",  longint'(out_valid16), 1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("hold_valid",  longint'(out_valid16), 0);
    chk("hold_sum_q",  longint'(sum_q16),     1);
    chk("hold_cout_q", longint'(cout_q16),    1);

    // saturation: 20 ops of 110 clamp the 4-bit counters at 15
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_op4",   longint'(op4),  15);
    chk("sat_car4",  longint'(car4), 15);
    chk("sat_op16",  longint'(op16), 20);
    // clear wins over a simultaneous accepted op; result path still captures
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("clr_op4",   longint'(op4),     0);
    chk("clr_car4",  longint'(car4),    0);
    chk("clr_sum_q", longint'(sum_q4),  1);
    chk("clr_cout_q", longint'(cout_q4), 0);

    // async reset between edges after nonzero state
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    a = 1'b0; b = 1'b1; cin = 1'b0;
    #1;
    check_comb();
    @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    #1;
    chk("valid_after_rel", longint'(out_valid16), 0);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("first_edge_valid", longint'(out_valid16), 1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      set_in(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 31) == 0));
      #1;
      check_comb();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: CNT_W, 16, width of the statistics counters (legal range 4..32).
REQ-002 Port: clk  input  1  single clock; all registers update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  1  addend bit A.
REQ-005 Port: b  input  1  addend bit B.
REQ-006 Port: cin  input  1  carry-in bit.
REQ-007 Port: sum  output  1  combinational sum = a ^ b ^ cin.
REQ-008 Port: cout  output  1  combinational carry = (a & b) | (cin & (a ^ b)).
REQ-009 Port: in_valid  input  1  qualifies a, b, cin for the registered path.
REQ-010 Port: sum_q  output  1  registered sum.
REQ-011 Port: cout_q  output  1  registered carry.
REQ-012 Port: out_valid  output  1  sum_q/cout_q hold a fresh result this cycle.
REQ-013 Port: clr  input  1  synchronous clear of the statistics counters.
REQ-014 Port: op_count  output  CNT_W  number of accepted operations.
REQ-015 Port: carry_count  output  CNT_W  number of accepted operations with cout = 1.

Function
REQ-016 sum and cout SHALL be purely combinational, valid in any cycle, independent of clk, rst_n, in_valid.
REQ-017 {cout, sum} SHALL equal the 2-bit value a + b + cin for all 8 input combinations.
REQ-018 On a rising clk edge with in_valid = 1, sum_q/cout_q SHALL capture the combinational sum/cout of that cycle's inputs (1-cycle latency).
REQ-019 out_valid SHALL be the registered copy of in_valid (high exactly one cycle after each accepted operation).
REQ-020 When in_valid = 0, sum_q and cout_q SHALL hold their previous values.
REQ-021 Each accepted operation SHALL increment op_count by 1; carry_count SHALL also increment by 1 when that operation's cout = 1.
REQ-022 Counters SHALL saturate at 2^CNT_W - 1 (no wrap-around); each saturates independently.
REQ-023 clr = 1 SHALL zero both counters at the next edge; clr takes priority over a simultaneous accepted operation (that operation is not counted), while the registered result path still captures it normally.
REQ-024 No handshake back-pressure exists: every cycle with in_valid = 1 is accepted.

Reset
REQ-025 rst_n = 0 SHALL immediately force sum_q = 0, cout_q = 0, out_valid = 0, op_count = 0, carry_count = 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard any captured-but-unreported result; out_valid stays 0 until the first accepted operation after deassertion.
REQ-027 Combinational sum/cout SHALL remain functional during reset.
REQ-028 The first rising edge at or after rst_n deassertion SHALL behave as a normal edge (inputs with in_valid = 1 are accepted).

Verification
REQ-029 Truth table, combinational: (a,b,cin) = 000->sum 0 cout 0; 010->1,0; 100->1,0; 110->0,1; 001->1,0; 011->0,1; 101->0,1; 111->1,1.
REQ-030 Registered path: in_valid = 1 with a=1,b=1,cin=1 at edge N -> sum_q=1, cout_q=1, out_valid=1 after edge N; in_valid=0 at edge N+1 -> out_valid=0, sum_q/cout_q unchanged.
REQ-031 Counters: apply all 8 combinations with in_valid = 1 -> op_count = 8, carry_count = 4.
REQ-032 Saturation with CNT_W = 4: 20 accepted ops of 110 -> op_count = 15, carry_count = 15; then clr = 1 for one cycle with in_valid = 1 -> both counters 0.
REQ-033 Async reset: assert rst_n = 0 between clock edges after nonzero state -> all registered outputs 0 before the next edge; combinational sum/cout still track a, b, cin.
